// File: rtl/edge_shift_data_path.sv
// Six-stage, 32-bit word shift register feeding the edge detector window.
// All stages are visible in parallel; window_valid flags a full window since reset.
module edge_shift_data_path (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic [31:0] data_in,
  output logic [31:0] w0,
  output logic [31:0] w1,
  output logic [31:0] w2,
  output logic [31:0] w3,
  output logic [31:0] w4,
  output logic [31:0] w5,
  output logic        window_valid
);

  localparam int unsigned DEPTH = 6;
  localparam logic [2:0]  FILL_FULL = 3'd6;

  logic [31:0] s_q [DEPTH];
  logic [31:0] s_d [DEPTH];
  logic [2:0]  fill_q;
  logic [2:0]  fill_d;

  // Reset wins over write; a write shifts every stage one step toward s5.
  always_comb begin
    s_d    = s_q;
    fill_d = fill_q;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) s_d[i] = '0;
      fill_d = '0;
    end else if (write_en) begin
      s_d[0] = data_in;
      for (int i = 1; i < DEPTH; i++) s_d[i] = s_q[i-1];
      if (fill_q != FILL_FULL) fill_d = fill_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    s_q    <= s_d;
    fill_q <= fill_d;
  end

  assign w0 = s_q[0];
  assign w1 = s_q[1];
  assign w2 = s_q[2];
  assign w3 = s_q[3];
  assign w4 = s_q[4];
  assign w5 = s_q[5];

  // Decoded directly from the registered counter, so no input-to-output path.
  assign window_valid = (fill_q == FILL_FULL);

endmodule

// File: tb/tb_edge_shift_data_path.sv
// Bench for edge_shift_data_path: directed plan plus random traffic,
// checked each cycle against a history-queue reference model.
module tb_edge_shift_data_path;

  localparam int W = 193;  // {window_valid, w5, w4, w3, w2, w1, w0}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_en = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] w0, w1, w2, w3, w4, w5;
  logic        window_valid;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  hist[$];   // newest write at index 0
  int           n_writes = 0;

  edge_shift_data_path dut (
    .clk          (clk),
    .rst          (rst),
    .write_en     (write_en),
    .data_in      (data_in),
    .w0           (w0),
    .w1           (w1),
    .w2           (w2),
    .w3           (w3),
    .w4           (w4),
    .w5           (w5),
    .window_valid (window_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model + driver ----------------
  function automatic logic [W-1:0] model_snapshot();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 6; i++)
      if (i < hist.size()) v[i*32 +: 32] = hist[i];
    v[W-1] = (n_writes >= 6);
    return v;
  endfunction

  task automatic drive(input logic r, input logic we, input logic [31:0] d);
    @(negedge clk);
    rst      = r;
    write_en = we;
    data_in  = d;
    if (r) begin
      hist.delete();
      n_writes = 0;
    end else if (we) begin
      hist.push_front(d);
      if (hist.size() > 6) void'(hist.pop_back());
      n_writes++;
    end
    exp_q.push_back(model_snapshot());
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [31:0]  act [6];
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act[0] = w0; act[1] = w1; act[2] = w2;
      act[3] = w3; act[4] = w4; act[5] = w5;
      for (int i = 0; i < 6; i++) begin
        total++;
        if (act[i] !== e[i*32 +: 32]) begin
          bad++;
          $display("FAIL w%0d at %0t: got %h expected %h", i, $time, act[i], e[i*32 +: 32]);
        end
      end
      total++;
      if (window_valid !== e[W-1]) begin
        bad++;
        $display("FAIL window_valid at %0t: got %b expected %b", $time, window_valid, e[W-1]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held two cycles with a write and all-ones data that must be ignored.
    drive(1'b1, 1'b1, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 32'hFFFF_FFFF);

    // Fill 1..6, then overflow with 7.
    for (int i = 1; i <= 7; i++) drive(1'b0, 1'b1, 32'(i));

    // Alternating enable with data incrementing every cycle.
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 14; i++) drive(1'b0, (i % 2) == 0, 32'(i));

    // Mid-stream reset with a colliding write, then a single write.
    drive(1'b1, 1'b1, 32'hA5A5_A5A5);
    drive(1'b0, 1'b1, 32'h1234_5678);
    drive(1'b0, 1'b0, 32'hDEAD_BEEF);

    // Bit integrity patterns.
    drive(1'b0, 1'b1, 32'h8000_0001);
    drive(1'b0, 1'b1, 32'h7FFF_FFFE);
    drive(1'b0, 1'b1, 32'h0000_0000);
    drive(1'b0, 1'b1, 32'hFFFF_FFFF);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom);

    // Back-to-back writes at full rate.
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, $urandom);

    drive(1'b0, 1'b0, 32'h0);

    // Drain: every pushed expectation must be consumed within a bounded wait.
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_shift_data_path.md
# edge_shift_data_path

Six-stage, 32-bit word shift register that supplies the edge detector's window logic with the six most recently written data words. Each accepted `data_in` word enters stage `w0`, and every older word moves one stage toward `w5`. All six stages are visible in parallel so downstream Sobel/compare logic can read the whole window in any cycle. The block also reports when the window holds six valid words since the last reset.

## Interface
- No parameters. Word width is fixed at 32 and depth at 6.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `write_en`  in  1  when high on a rising edge, shift the chain and load `data_in`.
- `data_in`  in  32  word to load into stage 0.
- `w0`  out  32  newest word (stage 0).
- `w1`..`w4`  out  32 each  intermediate stages; `w(i)` holds the word written i accepted writes ago.
- `w5`  out  32  oldest word (stage 5).
- `window_valid`  out  1  high once six or more writes have been accepted since reset.

## Operation
- State: six 32-bit registers `s0..s5` plus a 3-bit fill counter `fill` (range 0..6).
- Outputs map directly to state: `w(i)` = `s(i)`, with no combinational path from inputs.
- `window_valid` = (`fill` == 6), registered-equivalent.
- Priority on each rising edge: `rst` first, then `write_en`, then hold.
- Reset (`rst`=1):
  - All `s(i)` := 0 and `fill` := 0, regardless of `write_en`/`data_in`.
- Write (`rst`=0, `write_en`=1):
  - `s0` := `data_in`, and `s(i)` := `s(i-1)` for i=1..5.
  - The old `s5` is discarded.
  - `fill` := min(`fill`+1, 6), saturating at 6 with no wrap.
- Idle (`rst`=0, `write_en`=0): all registers hold.
- `data_in` is a don't-care when `write_en`=0 or `rst`=1.
- X/Z on `data_in` during a write propagates into the chain; no sanitising.
- No data transformation: words are copied bit-exact. No arithmetic other than the saturating counter.

## Timing
- Latency: a word sampled at edge N appears on `w0` after edge N. After k further accepted writes it is on `w(k)`, for k ≤ 5.
- Idle cycles do not advance the chain and do not count toward latency.
- Back-to-back writes on every cycle are supported at full clock rate.
- There is no ready/backpressure: every write is accepted.
- Reset is synchronous: asserting `rst` mid-stream clears all outputs and `window_valid` after that edge.
- A `write_en` asserted on the same edge as `rst` is lost.
- First write after reset: accepted on the first edge where `rst`=0.
- Power-up values before the first reset are unspecified; the system must apply reset before use.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with `write_en`=1 and `data_in`=0xFFFFFFFF -> `w0..w5`=0 and `window_valid`=0 after each edge.
- Fill: after reset, write 1,2,3,4,5,6 on consecutive cycles -> after the 6th edge `w0`=6, `w1`=5, `w2`=4, `w3`=3, `w4`=2, `w5`=1, and `window_valid`=1. `window_valid` is 0 after edges 1–5.
- Overflow/discard: continue writing 7 -> `w0`=7, `w5`=2; the word 1 is lost and `window_valid` stays 1.
- Alternating enable: toggle `write_en` each cycle while `data_in` increments from 0 every cycle -> only words sampled on enabled edges enter the chain (0,2,4,…), and registers hold on disabled cycles.
- Mid-stream reset: after the window is full, assert `rst` together with `write_en`=1 and `data_in`=0xA5A5A5A5 -> all outputs 0 and `window_valid`=0. The next write of 0x12345678 gives `w0`=0x12345678 and `w1..w5`=0.
- Bit integrity: write 0x80000001, then 0x7FFFFFFE, then 0x00000000, then 0xFFFFFFFF -> values reappear bit-exact on the correct stages (`w3`=0x80000001, `w2`=0x7FFFFFFE, `w1`=0x00000000, `w0`=0xFFFFFFFF).
